// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared processor constants for the integer register file.
// Rev    : 1.0
// ============================================================================
package reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : 2R/1W integer register file, x0 hardwired to zero, write bypass.
// Rev    : 1.0
// ============================================================================
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_port_addr1,
  input  logic [ADDR_W-1:0] read_port_addr2,
  input  logic [ADDR_W-1:0] write_port_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int                C_NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO  = ADDR_W'(REG_ZERO);

  // Entry 0 has no storage; it is synthesised as constant zero on the read side.
  logic [DATA_W-1:0] r_mem [1:C_NREGS-1];

  logic [DATA_W-1:0] w_mem_rd1;
  logic [DATA_W-1:0] w_mem_rd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < C_NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write_en && (write_port_addr != C_ZERO)) begin
      r_mem[write_port_addr] <= write_data;
    end
  end

  // Zero check, then bypass from the committing write, then stored value.
  function automatic logic [DATA_W-1:0] f_read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (addr == C_ZERO) begin
      return '0;
    end else if (wen && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  assign w_mem_rd1  = (read_port_addr1 == C_ZERO) ? '0 : r_mem[read_port_addr1];
  assign w_mem_rd2  = (read_port_addr2 == C_ZERO) ? '0 : r_mem[read_port_addr2];

  assign read_data1 = f_read_port(read_port_addr1, w_mem_rd1, write_en,
                                  write_port_addr, write_data);
  assign read_data2 = f_read_port(read_port_addr2, w_mem_rd2, write_en,
                                  write_port_addr, write_data);

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_file
// Brief  : Directed self-checking bench for reg_file.
// Rev    : 1.0
// ============================================================================
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  read_port_addr1;
  logic [4:0]  read_port_addr2;
  logic [4:0]  write_port_addr;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_cmp;
  int n_mis;

  reg_file dut (
    .clk             (clk),
    .rst             (rst),
    .read_port_addr1 (read_port_addr1),
    .read_port_addr2 (read_port_addr2),
    .write_port_addr (write_port_addr),
    .write_data      (write_data),
    .write_en        (write_en),
    .read_data1      (read_data1),
    .read_data2      (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_mis           = 0;
    rst             = 1'b1;
    write_en        = 1'b0;
    write_port_addr = 5'd0;
    write_data      = 32'h0;
    read_port_addr1 = 5'd1;
    read_port_addr2 = 5'd31;

    // Reset for one cycle, then read x1/x31
    tick();
    rst = 1'b0;
    #1;
    chk("reset_rd1_x1",  read_data1, 32'h0000_0000);
    chk("reset_rd2_x31", read_data2, 32'h0000_0000);

    // Write x1 then x2, two cycles each
    write_en        = 1'b1;
    write_port_addr = 5'd1;
    write_data      = 32'h0C70_F26F;
    #1;
    chk("bypass_x1", read_data1, 32'h0C70_F26F);
    tick();
    tick();
    write_port_addr = 5'd2;
    write_data      = 32'h0C70_F26E;
    tick();
    tick();
    write_en        = 1'b0;
    read_port_addr1 = 5'd1;
    read_port_addr2 = 5'd2;
    #1;
    chk("readback_x1", read_data1, 32'h0C70_F26F);
    chk("readback_x2", read_data2, 32'h0C70_F26E);

    // x0 is immutable and never bypassed
    write_en        = 1'b1;
    write_port_addr = 5'd0;
    write_data      = 32'hFFFF_FFFF;
    read_port_addr1 = 5'd0;
    read_port_addr2 = 5'd0;
    #1;
    chk("x0_no_bypass", read_data1, 32'h0000_0000);
    tick();
    write_en = 1'b0;
    #1;
    chk("x0_rd1", read_data1, 32'h0000_0000);
    chk("x0_rd2", read_data2, 32'h0000_0000);

    // Preload x3, then bypass a new value on both ports
    write_en        = 1'b1;
    write_port_addr = 5'd3;
    write_data      = 32'h1111_1111;
    tick();
    write_en        = 1'b0;
    read_port_addr1 = 5'd3;
    read_port_addr2 = 5'd3;
    #1;
    chk("x3_preload", read_data1, 32'h1111_1111);
    write_en   = 1'b1;
    write_data = 32'hAAAA_AAAA;
    #1;
    chk("bypass_rd1_x3", read_data1, 32'hAAAA_AAAA);
    chk("bypass_rd2_x3", read_data2, 32'hAAAA_AAAA);
    read_port_addr2 = 5'd1;
    #1;
    chk("no_bypass_rd2_x1", read_data2, 32'h0C70_F26F);
    tick();
    write_en = 1'b0;
    #1;
    chk("commit_x3", read_data1, 32'hAAAA_AAAA);

    // Disabled write is neither bypassed nor committed
    write_port_addr = 5'd4;
    write_data      = 32'hDEAD_BEEF;
    read_port_addr1 = 5'd4;
    #1;
    chk("wen0_no_bypass_x4", read_data1, 32'h0000_0000);
    tick();
    chk("wen0_x4", read_data1, 32'h0000_0000);

    // Top register boundary and neighbour isolation
    write_en        = 1'b1;
    write_port_addr = 5'd31;
    write_data      = 32'hCAFE_F00D;
    tick();
    write_en        = 1'b0;
    read_port_addr1 = 5'd30;
    read_port_addr2 = 5'd31;
    #1;
    chk("x30_untouched", read_data1, 32'h0000_0000);
    chk("x31_written",   read_data2, 32'hCAFE_F00D);

    // Reset beats a concurrent write; bypass stays live during reset
    rst             = 1'b1;
    write_en        = 1'b1;
    write_port_addr = 5'd5;
    write_data      = 32'h1234_5678;
    read_port_addr1 = 5'd5;
    read_port_addr2 = 5'd3;
    #1;
    chk("rst_bypass_x5", read_data1, 32'h1234_5678);
    tick();
    rst      = 1'b0;
    write_en = 1'b0;
    #1;
    chk("rst_prio_x5",  read_data1, 32'h0000_0000);
    chk("rst_clear_x3", read_data2, 32'h0000_0000);
    read_port_addr1 = 5'd1;
    read_port_addr2 = 5'd31;
    #1;
    chk("rst_clear_x1",  read_data1, 32'h0000_0000);
    chk("rst_clear_x31", read_data2, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_reg_file
`default_nettype wire
